// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem requests
// and buffers returned {instruction, PC} pairs in a DEPTH-entry FIFO popped by ID.
module fetch_queue #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic [31:0]                imem_data_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_inst_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] req_pc_reg, req_pc_next;
  logic            inflight_reg, inflight_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     pending;
  logic            req;
  logic            push;
  logic            pop;

  // Credit counts buffered entries plus the response still in flight, so a
  // granted request always has a free slot when its data returns.
  assign pending = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign req     = !rst_i && !redirect_i && (pending < (CW+1)'(DEPTH));
  assign push    = inflight_reg && !redirect_i;
  assign pop     = (count_reg != '0) && out_ready_i && !redirect_i;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    inflight_next = 1'b0;
    count_next    = count_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;

    if (redirect_i) begin
      fetch_pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      if (req) begin
        fetch_pc_next = fetch_pc_reg + XLEN'(4);
        req_pc_next   = fetch_pc_reg;
        inflight_next = 1'b1;
      end
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      inflight_reg <= inflight_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      inst_mem[wr_ptr_reg] <= imem_data_i;
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_reg;
  assign out_valid_o = (count_reg != '0);
  assign out_inst_o  = out_valid_o ? inst_mem[rd_ptr_reg] : 32'h0;
  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr_reg] : '0;
  assign count_o     = count_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4, RESET_PC=0x100) with a
// 1-cycle-latency instruction memory model whose data is a fixed function of address.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_inst_o    (out_inst),
    .out_pc_o      (out_pc),
    .count_o       (count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0F1E_2D3C;
  endfunction

  // Memory returns data one cycle after a request; garbage otherwise.
  always @(posedge clk) imem_data <= imem_req ? inst_of(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic [31:0] rp, input logic rdy,
                     input logic rq, input logic [31:0] a, input logic v, input logic [31:0] p,
                     input logic [2:0] c);
    vec_t x;
    x.rst = r; x.redir = rd; x.rpc = rp; x.rdy = rdy;
    x.req = rq; x.addr = a; x.vld = v; x.pc = p; x.cnt = c;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // cycles c0..c4: reset to 0x100, streaming with ready=1
    add(0,0,0,1, 1,32'h100,0,0,0);
    add(0,0,0,1, 1,32'h104,0,0,0);
    add(0,0,0,1, 1,32'h108,1,32'h100,1);
    add(0,0,0,1, 1,32'h10C,1,32'h104,1);
    add(0,0,0,1, 1,32'h110,1,32'h108,1);
    // redirect to 0, then fill with ready=0 and drain
    add(0,1,32'h0,1, 0,32'h114,1,32'h10C,1);
    add(0,0,0,0, 1,32'h0,0,0,0);
    add(0,0,0,0, 1,32'h4,0,0,0);
    add(0,0,0,0, 1,32'h8,1,32'h0,1);
    add(0,0,0,0, 1,32'hC,1,32'h0,2);
    add(0,0,0,0, 0,32'h10,1,32'h0,3);
    add(0,0,0,0, 0,32'h10,1,32'h0,4);
    add(0,0,0,0, 0,32'h10,1,32'h0,4);
    add(0,0,0,1, 0,32'h10,1,32'h0,4);
    add(0,0,0,1, 1,32'h10,1,32'h4,3);
    add(0,0,0,1, 1,32'h14,1,32'h8,2);
    add(0,0,0,1, 1,32'h18,1,32'hC,2);
    add(0,0,0,1, 1,32'h1C,1,32'h10,2);
    // redirect with count=2 and a response in flight
    add(0,1,32'h200,1, 0,32'h20,1,32'h14,2);
    add(0,0,0,1, 1,32'h200,0,0,0);
    add(0,0,0,1, 1,32'h204,0,0,0);
    add(0,0,0,1, 1,32'h208,1,32'h200,1);
    // unaligned target: low bits dropped
    add(0,1,32'h203,1, 0,32'h20C,1,32'h204,1);
    add(0,0,0,1, 1,32'h200,0,0,0);
    add(0,0,0,1, 1,32'h204,0,0,0);
    add(0,0,0,1, 1,32'h208,1,32'h200,1);
    // PC wrap at top of address space
    add(0,1,32'hFFFF_FFF8,1, 0,32'h20C,1,32'h204,1);
    add(0,0,0,1, 1,32'hFFFF_FFF8,0,0,0);
    add(0,0,0,1, 1,32'hFFFF_FFFC,0,0,0);
    add(0,0,0,1, 1,32'h0,1,32'hFFFF_FFF8,1);
    add(0,0,0,1, 1,32'h4,1,32'hFFFF_FFFC,1);
    add(0,0,0,1, 1,32'h8,1,32'h0,1);
    // build count=3 then reset mid-operation
    add(0,0,0,0, 1,32'hC,1,32'h4,1);
    add(0,0,0,0, 1,32'h10,1,32'h4,2);
    add(1,0,0,0, 0,32'h14,1,32'h4,3);
    add(0,0,0,1, 1,32'h100,0,0,0);
    add(0,0,0,1, 1,32'h104,0,0,0);
    add(0,0,0,1, 1,32'h108,1,32'h100,1);
    // back-to-back redirects: last wins
    add(0,1,32'h300,1, 0,32'h10C,1,32'h104,1);
    add(0,1,32'h400,1, 0,32'h300,0,0,0);
    add(0,0,0,1, 1,32'h400,0,0,0);
    add(0,0,0,1, 1,32'h404,0,0,0);
    add(0,0,0,1, 1,32'h408,1,32'h400,1);

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req",   {31'b0, imem_req},  32'h0);
    check("rst_addr",  imem_addr,          32'h100);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_inst",  out_inst,           32'h0);
    check("rst_pc",    out_pc,             32'h0);
    check("rst_count", {29'b0, count},     32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      #1;
      $display("[TB] vec %0d rst=%0b redir=%0b rdy=%0b -> req=%0b addr=%h valid=%0b pc=%h inst=%h count=%0d",
               i, rst, redirect, out_ready, imem_req, imem_addr, out_valid, out_pc, out_inst, count);
      check($sformatf("v%0d_req", i),   {31'b0, imem_req},  {31'b0, vecs[i].req});
      check($sformatf("v%0d_addr", i),  imem_addr,          vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].vld});
      check($sformatf("v%0d_pc", i),    out_pc,             vecs[i].pc);
      check($sformatf("v%0d_inst", i),  out_inst,           vecs[i].vld ? inst_of(vecs[i].pc) : 32'h0);
      check($sformatf("v%0d_count", i), {29'b0, count},     {29'b0, vecs[i].cnt});
    end

    // Redirect latency: target must become visible exactly 3 cycles after redirect.
    begin
      int k;
      bit seen;
      seen = 1'b0;
      k = 0;
      @(negedge clk);
      rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h500; out_ready = 1'b1;
      #1;
      @(negedge clk);
      redirect = 1'b0; redirect_pc = '0;
      for (int c = 1; c <= 8 && !seen; c++) begin
        if (c > 1) @(negedge clk);
        #1;
        if (out_valid) begin
          seen = 1'b1;
          k = c;
        end
      end
      $display("[TB] redirect latency: visible after %0d cycles pc=%h", k, out_pc);
      if (!seen) begin
        tests++;
        failed++;
        $display("FAIL lat_timeout: got no valid entry within 8 cycles, required one at 3");
      end else begin
        check("lat_cycles", k,      32'd3);
        check("lat_pc",     out_pc, 32'h500);
        check("lat_inst",   out_inst, inst_of(32'h500));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
